// File: rtl/tdi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tdi_pkg : opcodes, phase widths and phase descriptors for the TDI   |
// |           host initiator.                        Revision: 1.0      |
// +--------------------------------------------------------------------+
package tdi_pkg;

    localparam logic [7:0] OP_ID     = 8'hA1;
    localparam logic [7:0] OP_ID16   = 8'hA2;
    localparam logic [7:0] OP_HALT   = 8'hA4;
    localparam logic [7:0] OP_RESUME = 8'hA5;
    localparam logic [7:0] OP_RD     = 8'hA8;
    localparam logic [7:0] OP_WR     = 8'hA9;

    localparam logic [5:0] c_W8  = 6'd8;
    localparam logic [5:0] c_W16 = 6'd16;
    localparam logic [5:0] c_W32 = 6'd32;

    typedef enum logic [2:0] {
        PH_DONE    = 3'd0,
        PH_WR_OP   = 3'd1,
        PH_WR_ADDR = 3'd2,
        PH_WR_DATA = 3'd3,
        PH_RD      = 3'd4
    } phase_kind_e;

    typedef struct packed {
        phase_kind_e kind;
        logic [5:0]  width;
    } phase_desc_t;

    function automatic logic op_supported(input logic [7:0] op);
        return (op == OP_ID) || (op == OP_ID16) || (op == OP_HALT) ||
               (op == OP_RESUME) || (op == OP_RD) || (op == OP_WR);
    endfunction

    // Serial phase number idx of a frame; GAPs between phases are implicit.
    function automatic phase_desc_t phase_lookup(input logic [7:0] op, input logic [1:0] idx);
        phase_desc_t d;
        d = '{kind: PH_DONE, width: 6'd0};
        case (idx)
            2'd0: d = '{kind: PH_WR_OP, width: c_W8};
            2'd1: begin
                if (op == OP_ID16)                   d = '{kind: PH_RD, width: c_W16};
                else if (op == OP_RD || op == OP_WR) d = '{kind: PH_WR_ADDR, width: c_W32};
                else                                 d = '{kind: PH_RD, width: c_W8};
            end
            2'd2: begin
                if (op == OP_RD)      d = '{kind: PH_RD, width: c_W32};
                else if (op == OP_WR) d = '{kind: PH_WR_DATA, width: c_W32};
            end
            default: d = '{kind: PH_DONE, width: 6'd0};
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tdi_sck_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tdi_sck_gen : CLK_DIV divider producing SCK (idle high) and         |
// |               single-cycle rise/fall strikes.    Revision: 1.0      |
// +--------------------------------------------------------------------+
module tdi_sck_gen #(
    parameter int CLK_DIV = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic sck_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [7:0] c_DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div_q, div_d;
    logic       sck_q, sck_d;

    always_comb begin
        div_d = div_q;
        sck_d = sck_q;
        if (!en_i) begin
            div_d = 8'd0;
            sck_d = 1'b1;
        end else if (div_q == c_DIV_LAST) begin
            div_d = 8'd0;
            sck_d = ~sck_q;
        end else begin
            div_d = div_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            div_q <= 8'd0;
            sck_q <= 1'b1;
        end else begin
            div_q <= div_d;
            sck_q <= sck_d;
        end
    end

    // Strikes flag the HCLK edge at which SCK is about to change.
    assign rise_o = en_i && (div_q == c_DIV_LAST) && !sck_q;
    assign fall_o = en_i && (div_q == c_DIV_LAST) &&  sck_q;
    assign sck_o  = sck_q;

endmodule
`default_nettype wire

// File: rtl/tdi_host_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tdi_host_initiator : host-side TDI serial debug initiator; runs one |
// |                      command frame on SCK/SDI/SDO. Revision: 1.0    |
// +--------------------------------------------------------------------+
module tdi_host_initiator
    import tdi_pkg::*;
#(
    parameter int CLK_DIV = 8,
    parameter int GAP_CYC = 32
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        SCK,
    output logic        SDI,
    input  logic        SDO,
    input  logic        SDOE
);

    localparam int              c_GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT_OUT = 3'd1,
        GAP       = 3'd2,
        SHIFT_IN  = 3'd3,
        RESP      = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    phase_kind_e         kind_q, kind_d;
    logic [5:0]          width_q, width_d;
    logic [5:0]          bit_q, bit_d;
    logic [c_GAP_W-1:0]  gap_q, gap_d;
    logic [31:0]         sh_q, sh_d;
    logic                sdi_q, sdi_d;
    logic [7:0]          op_q, op_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;

    logic        w_sck_en, w_rise, w_fall, w_phase_end;
    logic [31:0] w_load;
    phase_desc_t w_next;
    logic        w_unused_sdoe;

    assign w_unused_sdoe = SDOE;
    assign w_sck_en      = (state_q == SHIFT_OUT) || (state_q == SHIFT_IN);
    assign w_next        = phase_lookup(op_q, idx_q + 2'd1);

    always_comb begin
        w_load = {24'h0, op_q};
        if (kind_q == PH_WR_ADDR)      w_load = addr_q;
        else if (kind_q == PH_WR_DATA) w_load = wdata_q;
    end

    tdi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk_i  (HCLK),
        .rst_ni (HRESETn),
        .en_i   (w_sck_en),
        .sck_o  (SCK),
        .rise_o (w_rise),
        .fall_o (w_fall)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        kind_d      = kind_q;
        width_d     = width_q;
        bit_d       = bit_q;
        gap_d       = gap_q;
        sh_d        = sh_q;
        sdi_d       = sdi_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        w_phase_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d       = cmd_op;
                    addr_d     = cmd_addr;
                    wdata_d    = cmd_wdata;
                    rsp_data_d = 32'h0;
                    rsp_err_d  = !op_supported(cmd_op);
                    idx_d      = 2'd0;
                    kind_d     = PH_WR_OP;
                    width_d    = c_W8;
                    bit_d      = 6'd0;
                    gap_d      = '0;
                    sh_d       = {24'h0, cmd_op};
                    sdi_d      = cmd_op[0];
                    state_d    = op_supported(cmd_op) ? SHIFT_OUT : RESP;
                end
            end
            SHIFT_OUT: begin
                // Bit 0 is already on SDI, so the first fall does not shift.
                if (w_fall && (bit_q != 6'd0)) begin
                    sh_d  = sh_q >> 1;
                    sdi_d = sh_q[1];
                end
                if (w_rise) begin
                    bit_d       = bit_q + 6'd1;
                    w_phase_end = (bit_d == width_q);
                end
            end
            SHIFT_IN: begin
                if (w_rise) begin
                    sh_d[bit_q[4:0]] = SDO;
                    bit_d            = bit_q + 6'd1;
                    w_phase_end      = (bit_d == width_q);
                end
            end
            GAP: begin
                if (gap_q == c_GAP_LAST) begin
                    gap_d = '0;
                    if (kind_q == PH_RD) begin
                        state_d = SHIFT_IN;
                        sh_d    = 32'h0;
                        sdi_d   = 1'b0;
                    end else begin
                        state_d = SHIFT_OUT;
                        sh_d    = w_load;
                        sdi_d   = w_load[0];
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (w_phase_end) begin
            bit_d = 6'd0;
            if (w_next.kind == PH_DONE) begin
                state_d = RESP;
                if (kind_q == PH_RD) rsp_data_d = sh_d;
            end else begin
                state_d = GAP;
                idx_d   = idx_q + 2'd1;
                kind_d  = w_next.kind;
                width_d = w_next.width;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            kind_q     <= PH_DONE;
            width_q    <= 6'd0;
            bit_q      <= 6'd0;
            gap_q      <= '0;
            sh_q       <= 32'h0;
            sdi_q      <= 1'b0;
            op_q       <= 8'h0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            rsp_data_q <= 32'h0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            kind_q     <= kind_d;
            width_q    <= width_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
            sh_q       <= sh_d;
            sdi_q      <= sdi_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign SDI       = sdi_q;

endmodule
`default_nettype wire
